// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_mux
// Description : Four-digit multiplexed seven-segment driver for a stopwatch.
//               Scans sec_r, sec_l, min_r, min_l on anodes 0..3, blanks each
//               slot briefly to suppress ghosting, shows the min/sec separator
//               on slot 2 and blinks the whole display while paused. Digits
//               are taken from a per-frame snapshot so a frame is never torn.
// Revision    : 1.0 - initial release
// ============================================================================
module display_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 8,
    parameter int BLINK_DIV    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] min_l,
    input  logic [4:0] min_r,
    input  logic [4:0] sec_l,
    input  logic [4:0] sec_r,
    input  logic       paused,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    // Counter widths; a divide of 1 still needs a one-bit register.
    localparam int c_RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_RW-1:0] c_REF_MAX   = c_RW'(REFRESH_DIV - 1);
    localparam logic [c_RW-1:0] c_BLANK     = c_RW'(BLANK_CYCLES);
    localparam logic [c_BW-1:0] c_BLINK_MAX = c_BW'(BLINK_DIV - 1);

    localparam logic [1:0] c_SLOT_SEP  = 2'd2;
    localparam logic [1:0] c_SLOT_LAST = 2'd3;

    localparam logic [6:0] c_SEG_OFF = 7'b1111111;
    localparam logic [3:0] c_AN_OFF  = 4'b1111;

    // Scan / blink state
    logic [c_RW-1:0] r_refresh_cnt;
    logic [1:0]      r_slot;
    logic [c_BW-1:0] r_blink_cnt;
    logic            r_phase_on;
    // Snapshot, index 0 = sec_r (rightmost) ... index 3 = min_l
    logic [3:0][4:0] r_snap;

    // Registered outputs
    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] r_an;

    // Combinational helpers
    logic       w_refresh_wrap;
    logic       w_frame_end;
    logic       w_blink_wrap;
    logic       w_blank;
    logic [4:0] w_digit;
    logic [6:0] w_seg_dec;
    logic [3:0] w_an_next;
    logic       w_dp_next;

    assign w_refresh_wrap = (r_refresh_cnt == c_REF_MAX);
    assign w_frame_end    = w_refresh_wrap && (r_slot == c_SLOT_LAST);
    assign w_blink_wrap   = (r_blink_cnt == c_BLINK_MAX);
    assign w_blank        = (r_refresh_cnt < c_BLANK);
    assign w_digit        = r_snap[r_slot];

    // Refresh counter and slot index; they keep scanning regardless of paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_slot        <= '0;
        end else if (w_refresh_wrap) begin
            r_refresh_cnt <= '0;
            r_slot        <= r_slot + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Capture all four digits together as the scan wraps from slot 3 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_frame_end) begin
            r_snap <= {min_l, min_r, sec_l, sec_r};
        end
    end

    // Blink timer: idle and forced on while running, toggles each wrap when paused.
    always_ff @(posedge clk) begin
        if (rst || !paused) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Active-low seven-segment decode of the active slot's snapshot digit.
    always_comb begin
        w_seg_dec = c_SEG_OFF;
        case (w_digit)
            5'd0:    w_seg_dec = 7'b1000000;
            5'd1:    w_seg_dec = 7'b1111001;
            5'd2:    w_seg_dec = 7'b0100100;
            5'd3:    w_seg_dec = 7'b0110000;
            5'd4:    w_seg_dec = 7'b0011001;
            5'd5:    w_seg_dec = 7'b0010010;
            5'd6:    w_seg_dec = 7'b0000010;
            5'd7:    w_seg_dec = 7'b1111000;
            5'd8:    w_seg_dec = 7'b0000000;
            5'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = c_SEG_OFF;
        endcase
    end

    // Anode and separator: dark during the blank window or the blink off phase.
    always_comb begin
        w_an_next = c_AN_OFF;
        w_dp_next = 1'b1;
        if (!w_blank && r_phase_on) begin
            w_an_next = ~(4'b0001 << r_slot);
            w_dp_next = (r_slot != c_SLOT_SEP);
        end
    end

    // Output register: one cycle behind the scan state, glitch-free pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= c_SEG_OFF;
            r_dp  <= 1'b1;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= w_seg_dec;
            r_dp  <= w_dp_next;
            r_an  <= w_an_next;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_mux
// Description : Self-checking bench for display_mux with a cycle-count based
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mux;

    localparam int c_D  = 4;
    localparam int c_BL = 1;
    localparam int c_B  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] min_l = '0, min_r = '0, sec_l = '0, sec_r = '0;
    logic       paused = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_pass  = 0;
    int n_total = 0;

    display_mux #(
        .REFRESH_DIV (c_D),
        .BLANK_CYCLES(c_BL),
        .BLINK_DIV   (c_B)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .min_l (min_l),
        .min_r (min_r),
        .sec_l (sec_l),
        .sec_r (sec_r),
        .paused(paused),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_k: edges since reset, m_p: consecutive paused edges, m_snap: frame digits
    int         m_k = 0;
    int         m_p = 0;
    logic [4:0] m_snap [4];
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;

    function automatic logic [6:0] f_dec(input logic [4:0] v);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (v < 5'd10) ? t[v] : 7'b1111111;
    endfunction

    function automatic bit f_lit(input int k, input int p);
        return ((k % c_D) >= c_BL) && (((p / c_B) % 2) == 0);
    endfunction

    function automatic logic [3:0] f_an(input int k, input int p);
        int slot;
        slot = (k / c_D) % 4;
        return f_lit(k, p) ? ~(4'b0001 << slot) : 4'b1111;
    endfunction

    function automatic logic f_dp(input int k, input int p);
        return !(f_lit(k, p) && (((k / c_D) % 4) == 2));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            m_k     <= 0;
            m_p     <= 0;
            for (int i = 0; i < 4; i++) m_snap[i] <= '0;
        end else begin
            exp_an  <= f_an(m_k, m_p);
            exp_seg <= f_dec(m_snap[(m_k / c_D) % 4]);
            exp_dp  <= f_dp(m_k, m_p);
            m_k     <= m_k + 1;
            m_p     <= paused ? m_p + 1 : 0;
            if (((m_k + 1) % (4 * c_D)) == 0) begin
                m_snap[0] <= sec_r;
                m_snap[1] <= sec_l;
                m_snap[2] <= min_r;
                m_snap[3] <= min_l;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
                $display("FAIL reset_hold an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp);
            else n_pass++;
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] want_an;
            @(negedge clk);
            want_an = ((i % 4) == 0) ? 4'hF : ~(4'b0001 << (i / 4));
            n_total++;
            if (an !== want_an || seg !== 7'b1000000)
                $display("FAIL reset_scan cyc=%0d an=%b seg=%b want an=%b seg=1000000", i, an, seg, want_an);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] want [4];
        bit         found;
        want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        repeat (2) @(negedge clk);
        min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
        for (int i = 0; i < 4 * c_D + 2; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL snapshot_model an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
            else n_pass++;
        end
        for (int s = 0; s < 4; s++) begin
            found = 0;
            for (int t = 0; t < 40 && !found; t++) begin
                @(negedge clk);
                if (an === ~(4'b0001 << s)) found = 1;
            end
            n_total++;
            if (!found || seg !== want[s])
                $display("FAIL snapshot_digit slot=%0d found=%0d seg=%b want %b", s, found, seg, want[s]);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        bit found;
        sec_r = 5'd12;
        for (int i = 0; i < 5 * c_D * 4; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL oor_model an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
            else n_pass++;
        end
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (an === 4'b1110) found = 1;
        end
        n_total++;
        if (!found || seg !== 7'b1111111)
            $display("FAIL oor_blank found=%0d seg=%b want 1111111", found, seg);
        else n_pass++;
    endtask

    task automatic test_separator();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_total++;
            if (dp !== ((an === 4'b1011) ? 1'b0 : 1'b1) || dp !== exp_dp)
                $display("FAIL separator an=%b dp=%b want dp=%b", an, dp, exp_dp);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        int budget;
        paused = 1'b1;
        for (int i = 0; i < 3 * c_B + 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL blink_model an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
            else n_pass++;
        end
        budget = 0;
        while (((m_p / c_B) % 2) == 0 && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        n_total++;
        if (budget >= 64) $display("FAIL blink_off_timeout waited=%0d want <64", budget);
        else n_pass++;
        repeat (3) @(negedge clk);
        paused = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL blink_resume an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, exp_seg, exp_dp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        paused = 1'b1;
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (an === 4'b1011) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL rstmid_slot2_timeout an=%b want 1011", an);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL rstmid_hold an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] want_an;
            @(negedge clk);
            want_an = ((i % 4) == 0) ? 4'hF : ~(4'b0001 << (i / 4));
            n_total++;
            if (an !== want_an || seg !== 7'b1000000 || an !== exp_an)
                $display("FAIL rstmid_restart cyc=%0d an=%b seg=%b want an=%b seg=1000000", i, an, seg, want_an);
            else n_pass++;
        end
        paused = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n_total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
                $display("FAIL random cyc=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
            else n_pass++;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) paused = ~paused;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: min_l = 5'($urandom_range(0, 31));
                    1: min_r = 5'($urandom_range(0, 31));
                    2: sec_l = 5'($urandom_range(0, 31));
                    default: sec_r = 5'($urandom_range(0, 31));
                endcase
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_out_of_range();
        test_separator();
        test_blink();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
- Parameters:
  - REQ-001: REFRESH_DIV, default 100000, sets clk cycles per digit slot; legal range is 2 or more.
  - REQ-002: BLANK_CYCLES, default 8, sets the anode-off cycles at the start of each slot; legal range is 0 to REFRESH_DIV-1.
  - REQ-003: BLINK_DIV, default 50000000, sets clk cycles per blink half-period; legal range is 1 or more.
- Ports (name, direction, width, meaning):
  - REQ-004: clk, input, 1, sole clock; all logic on its rising edge.
  - REQ-005: rst, input, 1, synchronous active-high reset.
  - REQ-006: min_l, input, 5, minutes tens digit from the counter.
  - REQ-007: min_r, input, 5, minutes units digit.
  - REQ-008: sec_l, input, 5, seconds tens digit.
  - REQ-009: sec_r, input, 5, seconds units digit.
  - REQ-010: paused, input, 1, stopwatch paused; enables blinking.
  - REQ-011: seg, output, 7, active-low cathodes {g,f,e,d,c,b,a}.
  - REQ-012: dp, output, 1, active-low decimal point.
  - REQ-013: an, output, 4, active-low anodes; an[0] is the rightmost digit (sec_r), an[3] is min_l.

Function
- REQ-014: A refresh counter counts 0..REFRESH_DIV-1 and wraps to 0. Each wrap advances the slot index 0->1->2->3->0.
- REQ-015: Slot mapping: 0 is sec_r/an[0], 1 is sec_l/an[1], 2 is min_r/an[2], 3 is min_l/an[3].
- REQ-016: On the cycle the slot index advances from 3 to 0, all four digit inputs are captured into a snapshot register. The display shows only snapshot values, so a frame is never torn.
- REQ-017: Digit decode uses snapshot value v:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..31 gives 1111111 (blank).
- REQ-018: While the refresh counter is below BLANK_CYCLES, an is 1111 (ghost suppression). Otherwise the active slot's anode bit alone is 0.
- REQ-019: dp is 0 only when slot 2 is active, not blanked and the blink phase is on; otherwise dp is 1. This gives the minutes/seconds separator.
- REQ-020: Blink: while paused=1, a blink counter counts 0..BLINK_DIV-1 and toggles the blink phase on each wrap. While the phase is off, an is 1111 and dp is 1.
- REQ-021: When paused=0, the blink counter is held at 0 and the phase is forced on. When paused rises, the display stays on for a full BLINK_DIV cycles before the first off phase.
- REQ-022: seg, dp and an are registered. Each is a function of the counter/slot/phase state of the previous cycle, giving 1-cycle latency.
- REQ-023: seg always shows the active slot's decode, even while an is blanked.
- REQ-024: Input changes between snapshots have no effect on outputs until the next slot-3-to-0 transition.
- REQ-025: The refresh counter and slot index run regardless of paused.

Reset
- REQ-026: While rst=1 at a clock edge, the following are cleared:
  - refresh counter to 0, slot index to 0, blink counter to 0;
  - blink phase to on;
  - snapshot to all zeros.
- REQ-027: The same edge sets the outputs to an=1111, seg=1111111, dp=1.
- REQ-028: rst has priority over all other activity. Reset asserted mid-frame aborts the frame.
- REQ-029: On the first cycle after rst falls, the outputs follow normal operation from slot 0 with the snapshot at 0000.
- REQ-030: Snapshot capture during reset does not occur; reset wins.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_DIV=16)
- REQ-031: Reset scenario: pulse rst for 2 cycles -> during reset an=1111, seg=1111111, dp=1. Then each slot shows an=1111 for 1 cycle followed by its anode low for 3 cycles, in order an[0],an[1],an[2],an[3]. seg=1000000 throughout.
- REQ-032: Snapshot scenario: digits 1,2,3,4 (min_l..sec_r) applied mid-frame -> unchanged 0000 until the slot-3-to-0 transition. Afterwards an[0] shows 0011001, an[1] 0110000, an[2] 0100100, an[3] 1111001.
- REQ-033: Out-of-range scenario: sec_r=12, other digits valid -> the slot 0 seg is 1111111 while the other digits decode normally.
- REQ-034: Separator scenario: any valid frame -> dp=0 only during the unblanked cycles of slot 2; dp=1 elsewhere.
- REQ-035: Blink scenario: assert paused -> displays on for 16 cycles, then an=1111 and dp=1 for 16 cycles, repeating. Deassert paused during an off phase -> the display is on again by the next cycle's registered output.
- REQ-036: Reset-mid-operation scenario: assert rst while slot 2 is active and paused=1 -> the state is cleared. After release, scanning restarts at slot 0, the phase is on and the display shows 0000.
